// File: rtl/hdmi_rx_unpack.sv
// GT RX video unpacker: recovers byte alignment from the comma, decodes framing control
// words and emits a frame-sync pulse plus a line-gated 32-bit pixel-pair stream.
module hdmi_rx_unpack #(
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter logic [7:0]  K_CHAR     = 8'hBC
) (
    input  logic        rst,
    input  logic        tx_clk,
    input  logic [31:0] gt_rx_data,
    input  logic [3:0]  gt_rx_ctrl,
    input  logic [15:0] expected_width,
    output logic        vout_vs,
    output logic        vout_de,
    output logic [31:0] vout_data,
    output logic [15:0] line_cnt,
    output logic        locked,
    output logic [1:0]  lane,
    output logic        len_err,
    output logic        proto_err
);
    // Output stream: vout_de qualifies vout_data for exactly one cycle per word; there is
    // no backpressure, the downstream FIFO must accept every word presented with vout_de=1.

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam int UW = $clog2(UNLOCK_CNT + 1);

    localparam logic [23:0] C_SYNC0  = 24'hFF0000;
    localparam logic [23:0] C_SYNC1  = 24'hFF0001;
    localparam logic [23:0] C_LSTART = 24'hFF0002;
    localparam logic [23:0] C_LEND   = 24'hFF0003;
    localparam logic [23:0] C_IDLE_A = 24'hFF5555;
    localparam logic [23:0] C_IDLE_B = 24'hFFAAAA;

    typedef enum logic {
        S_UNLOCKED,
        S_LOCKED
    } lock_state_t;

    typedef enum logic [1:0] {
        P_IDLE,
        P_SYNC_SEEN,
        P_LINE
    } parse_state_t;

    lock_state_t  lock_state;
    parse_state_t parse_state;

    logic [31:0] rx_d1, rx_d2;
    logic [3:0]  ctrl_d1, ctrl_d2;

    logic [CW-1:0] comma_cnt;
    logic [CW-1:0] comma_next;
    logic [1:0]    cand_lane;
    logic [UW-1:0] bad_cnt;
    logic [15:0]   word_cnt;

    logic        raw_onehot;
    logic [1:0]  raw_lane;
    logic [7:0]  raw_kbyte;
    logic        raw_comma;
    logic        raw_bad;

    logic [31:0] a_word;
    logic [3:0]  a_ctrl;
    logic        a_is_data;
    logic        a_is_k;
    logic        is_sync0, is_sync1, is_lstart, is_lend, is_idle;
    logic        a_known;
    logic        a_bad;
    logic        lock_drop;
    logic [15:0] req_words;
    logic [15:0] word_cnt_inc;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            rx_d1   <= '0;
            rx_d2   <= '0;
            ctrl_d1 <= '0;
            ctrl_d2 <= '0;
        end else begin
            rx_d1   <= gt_rx_data;
            rx_d2   <= rx_d1;
            ctrl_d1 <= gt_rx_ctrl;
            ctrl_d2 <= ctrl_d1;
        end
    end

    // Comma search runs on the raw GT word so lock can be found in any byte lane.
    always_comb begin
        raw_onehot = 1'b1;
        raw_lane   = 2'd0;
        raw_kbyte  = gt_rx_data[7:0];
        case (gt_rx_ctrl)
            4'b0001: begin raw_lane = 2'd0; raw_kbyte = gt_rx_data[7:0];   end
            4'b0010: begin raw_lane = 2'd1; raw_kbyte = gt_rx_data[15:8];  end
            4'b0100: begin raw_lane = 2'd2; raw_kbyte = gt_rx_data[23:16]; end
            4'b1000: begin raw_lane = 2'd3; raw_kbyte = gt_rx_data[31:24]; end
            default: raw_onehot = 1'b0;
        endcase
        raw_comma = raw_onehot && (raw_kbyte == K_CHAR);
        raw_bad   = (gt_rx_ctrl != 4'b0000) && !raw_comma;
    end

    always_comb begin
        if ((cand_lane == raw_lane) && (comma_cnt != '0)) begin
            comma_next = comma_cnt + 1'b1;
        end else begin
            comma_next = CW'(1);
        end
    end

    // The aligned word straddles the two delayed words: low bytes come from the older one.
    always_comb begin
        a_word = rx_d2;
        a_ctrl = ctrl_d2;
        case (lane)
            2'd1: begin
                a_word = {rx_d1[7:0], rx_d2[31:8]};
                a_ctrl = {ctrl_d1[0], ctrl_d2[3:1]};
            end
            2'd2: begin
                a_word = {rx_d1[15:0], rx_d2[31:16]};
                a_ctrl = {ctrl_d1[1:0], ctrl_d2[3:2]};
            end
            2'd3: begin
                a_word = {rx_d1[23:0], rx_d2[31:24]};
                a_ctrl = {ctrl_d1[2:0], ctrl_d2[3]};
            end
            default: ;
        endcase
    end

    always_comb begin
        a_is_data = (a_ctrl == 4'b0000);
        a_is_k    = (a_ctrl == 4'b0001) && (a_word[7:0] == K_CHAR);
        is_sync0  = a_is_k && (a_word[31:8] == C_SYNC0);
        is_sync1  = a_is_k && (a_word[31:8] == C_SYNC1);
        is_lstart = a_is_k && (a_word[31:8] == C_LSTART);
        is_lend   = a_is_k && (a_word[31:8] == C_LEND);
        is_idle   = a_is_k && ((a_word[31:8] == C_IDLE_A) || (a_word[31:8] == C_IDLE_B));
        a_known   = is_sync0 || is_sync1 || is_lstart || is_lend || is_idle;
        a_bad     = !a_is_data && !a_known;
        lock_drop = (lock_state == S_LOCKED) && a_bad && (bad_cnt == UW'(UNLOCK_CNT - 1));
    end

    assign req_words    = expected_width >> 1;
    assign word_cnt_inc = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            lock_state <= S_UNLOCKED;
            comma_cnt  <= '0;
            cand_lane  <= 2'd0;
            bad_cnt    <= '0;
            lane       <= 2'd0;
            locked     <= 1'b0;
        end else begin
            case (lock_state)
                S_UNLOCKED: begin
                    if (raw_comma) begin
                        cand_lane <= raw_lane;
                        if (comma_next == CW'(LOCK_CNT)) begin
                            lock_state <= S_LOCKED;
                            lane       <= raw_lane;
                            locked     <= 1'b1;
                            comma_cnt  <= '0;
                            bad_cnt    <= '0;
                        end else begin
                            comma_cnt <= comma_next;
                        end
                    end else if (raw_bad) begin
                        comma_cnt <= '0;
                    end
                end
                S_LOCKED: begin
                    if (lock_drop) begin
                        lock_state <= S_UNLOCKED;
                        locked     <= 1'b0;
                        comma_cnt  <= '0;
                        bad_cnt    <= '0;
                    end else if (a_bad) begin
                        bad_cnt <= bad_cnt + 1'b1;
                    end else if (a_known) begin
                        bad_cnt <= '0;
                    end
                end
                default: lock_state <= S_UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            parse_state <= P_IDLE;
            word_cnt    <= '0;
            line_cnt    <= '0;
            vout_vs     <= 1'b0;
            vout_de     <= 1'b0;
            vout_data   <= '0;
            len_err     <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            vout_vs   <= 1'b0;
            vout_de   <= 1'b0;
            len_err   <= 1'b0;
            proto_err <= 1'b0;
            if (lock_state != S_LOCKED) begin
                parse_state <= P_IDLE;
            end else begin
                case (parse_state)
                    P_IDLE: begin
                        if (is_sync0) begin
                            parse_state <= P_SYNC_SEEN;
                        end else if (is_lstart) begin
                            parse_state <= P_LINE;
                            word_cnt    <= '0;
                        end else if (!is_idle) begin
                            proto_err <= 1'b1;
                        end
                    end
                    P_SYNC_SEEN: begin
                        if (is_sync1) begin
                            vout_vs     <= 1'b1;
                            line_cnt    <= '0;
                            parse_state <= P_IDLE;
                        end else begin
                            // Broken sync pair: flag it, then treat this word as if seen in IDLE.
                            proto_err <= 1'b1;
                            if (is_sync0) begin
                                parse_state <= P_SYNC_SEEN;
                            end else if (is_lstart) begin
                                parse_state <= P_LINE;
                                word_cnt    <= '0;
                            end else begin
                                parse_state <= P_IDLE;
                            end
                        end
                    end
                    P_LINE: begin
                        if (a_is_data) begin
                            vout_de   <= 1'b1;
                            vout_data <= a_word;
                            word_cnt  <= word_cnt_inc;
                        end else if (is_lend) begin
                            parse_state <= P_IDLE;
                            line_cnt    <= line_cnt + 16'd1;
                            len_err     <= (word_cnt != req_words);
                        end else if (is_sync0) begin
                            proto_err   <= 1'b1;
                            parse_state <= P_SYNC_SEEN;
                        end else begin
                            proto_err   <= 1'b1;
                            parse_state <= P_IDLE;
                        end
                    end
                    default: parse_state <= P_IDLE;
                endcase
                if (lock_drop) begin
                    parse_state <= P_IDLE;
                    if (parse_state == P_LINE) begin
                        proto_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hdmi_rx_unpack.sv
// Directed bench for hdmi_rx_unpack: logical words are rotated onto the GT port per lane,
// every output is logged per cycle and compared against hand-computed expectations.
module tb_hdmi_rx_unpack;

    logic        rst;
    logic        tx_clk;
    logic [31:0] gt_rx_data;
    logic [3:0]  gt_rx_ctrl;
    logic [15:0] expected_width;
    logic        vout_vs;
    logic        vout_de;
    logic [31:0] vout_data;
    logic [15:0] line_cnt;
    logic        locked;
    logic [1:0]  lane;
    logic        len_err;
    logic        proto_err;

    hdmi_rx_unpack dut (
        .rst            (rst),
        .tx_clk         (tx_clk),
        .gt_rx_data     (gt_rx_data),
        .gt_rx_ctrl     (gt_rx_ctrl),
        .expected_width (expected_width),
        .vout_vs        (vout_vs),
        .vout_de        (vout_de),
        .vout_data      (vout_data),
        .line_cnt       (line_cnt),
        .locked         (locked),
        .lane           (lane),
        .len_err        (len_err),
        .proto_err      (proto_err)
    );

    // Clock / reset
    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    localparam logic [31:0] W_SYNC0  = 32'hFF0000BC;
    localparam logic [31:0] W_SYNC1  = 32'hFF0001BC;
    localparam logic [31:0] W_LSTART = 32'hFF0002BC;
    localparam logic [31:0] W_LEND   = 32'hFF0003BC;

    int checks;
    int errors;
    int cyc;
    int tb_lane;
    logic        idle_sel;
    logic [31:0] prev_w;
    logic [3:0]  prev_c;

    logic        rec_vs     [0:511];
    logic        rec_de     [0:511];
    logic [31:0] rec_data   [0:511];
    logic [15:0] rec_lc     [0:511];
    logic        rec_locked [0:511];
    logic [1:0]  rec_lane   [0:511];
    logic        rec_len    [0:511];
    logic        rec_proto  [0:511];

    // Driver tasks: one raw GT word per cycle; entry k holds outputs sampled after edge k.
    task automatic step(input logic [31:0] d, input logic [3:0] c);
        gt_rx_data = d;
        gt_rx_ctrl = c;
        @(posedge tx_clk);
        #1;
        if (cyc < 512) begin
            rec_vs[cyc]     = vout_vs;
            rec_de[cyc]     = vout_de;
            rec_data[cyc]   = vout_data;
            rec_lc[cyc]     = line_cnt;
            rec_locked[cyc] = locked;
            rec_lane[cyc]   = lane;
            rec_len[cyc]    = len_err;
            rec_proto[cyc]  = proto_err;
        end
        cyc++;
    endtask

    task automatic send(input logic [31:0] w, input logic [3:0] c);
        logic [63:0] p;
        logic [7:0]  q;
        p = {w, prev_w} >> (32 - 8 * tb_lane);
        q = {c, prev_c} >> (4 - tb_lane);
        prev_w = w;
        prev_c = c;
        step(p[31:0], q[3:0]);
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) begin
            send(idle_sel ? 32'hFFAAAABC : 32'hFF5555BC, 4'b0001);
            idle_sel = ~idle_sel;
        end
    endtask

    task automatic reset_dut(input int new_lane);
        rst        = 1'b1;
        gt_rx_data = '0;
        gt_rx_ctrl = '0;
        prev_w     = '0;
        prev_c     = '0;
        idle_sel   = 1'b0;
        tb_lane    = new_lane;
        repeat (2) @(posedge tx_clk);
        #3;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset;
        reset_dut(0);
        checks++; if (vout_vs !== 1'b0) begin errors++; $display("FAIL rst_vs got=%0b exp=0", vout_vs); end
        checks++; if (vout_de !== 1'b0) begin errors++; $display("FAIL rst_de got=%0b exp=0", vout_de); end
        checks++; if (vout_data !== 32'h0) begin errors++; $display("FAIL rst_data got=%h exp=0", vout_data); end
        checks++; if (line_cnt !== 16'h0) begin errors++; $display("FAIL rst_line_cnt got=%0d exp=0", line_cnt); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got=%0b exp=0", locked); end
        checks++; if (lane !== 2'd0) begin errors++; $display("FAIL rst_lane got=%0d exp=0", lane); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got=%0b exp=0", len_err); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got=%0b exp=0", proto_err); end
    endtask

    task automatic test_lock_lane0;
        reset_dut(0);
        expected_width = 16'd8;
        send_idle(20);
        checks++; if (rec_locked[14] !== 1'b0) begin errors++; $display("FAIL lock0_early got=%0b exp=0", rec_locked[14]); end
        checks++; if (rec_locked[15] !== 1'b1) begin errors++; $display("FAIL lock0_at16 got=%0b exp=1", rec_locked[15]); end
        checks++; if (rec_lane[15] !== 2'd0) begin errors++; $display("FAIL lock0_lane got=%0d exp=0", rec_lane[15]); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (rec_vs[i] !== 1'b0 || rec_de[i] !== 1'b0 || rec_len[i] !== 1'b0 || rec_proto[i] !== 1'b0) begin
                errors++;
                $display("FAIL lock0_quiet cyc=%0d vs=%0b de=%0b len=%0b proto=%0b exp all 0", i, rec_vs[i], rec_de[i], rec_len[i], rec_proto[i]);
            end
        end
    endtask

    task automatic test_line_lane2;
        logic [31:0] exp_d;
        reset_dut(2);
        expected_width = 16'd8;
        send_idle(20);
        send(W_SYNC0, 4'b0001);
        send(W_SYNC1, 4'b0001);
        send(W_LSTART, 4'b0001);
        send(32'h11111111, 4'b0000);
        send(32'h22222222, 4'b0000);
        send(32'h33333333, 4'b0000);
        send(32'h44444444, 4'b0000);
        send(W_LEND, 4'b0001);
        send_idle(4);
        checks++; if (rec_locked[15] !== 1'b1) begin errors++; $display("FAIL lane2_lock got=%0b exp=1", rec_locked[15]); end
        checks++; if (rec_lane[20] !== 2'd2) begin errors++; $display("FAIL lane2_lane got=%0d exp=2", rec_lane[20]); end
        checks++; if (rec_vs[22] !== 1'b0) begin errors++; $display("FAIL lane2_vs_pre got=%0b exp=0", rec_vs[22]); end
        checks++; if (rec_vs[23] !== 1'b1) begin errors++; $display("FAIL lane2_vs got=%0b exp=1", rec_vs[23]); end
        checks++; if (rec_vs[24] !== 1'b0) begin errors++; $display("FAIL lane2_vs_post got=%0b exp=0", rec_vs[24]); end
        checks++; if (rec_lc[23] !== 16'd0) begin errors++; $display("FAIL lane2_lc_vs got=%0d exp=0", rec_lc[23]); end
        checks++; if (rec_de[24] !== 1'b0) begin errors++; $display("FAIL lane2_de_lstart got=%0b exp=0", rec_de[24]); end
        for (int i = 0; i < 4; i++) begin
            exp_d = 32'h11111111 * (i + 1);
            checks++;
            if (rec_de[25 + i] !== 1'b1 || rec_data[25 + i] !== exp_d) begin
                errors++;
                $display("FAIL lane2_data idx=%0d de=%0b data=%h exp de=1 data=%h", i, rec_de[25 + i], rec_data[25 + i], exp_d);
            end
        end
        checks++; if (rec_de[29] !== 1'b0) begin errors++; $display("FAIL lane2_de_lend got=%0b exp=0", rec_de[29]); end
        checks++; if (rec_lc[29] !== 16'd1) begin errors++; $display("FAIL lane2_line_cnt got=%0d exp=1", rec_lc[29]); end
        checks++; if (rec_data[31] !== 32'h44444444) begin errors++; $display("FAIL lane2_data_hold got=%h exp=44444444", rec_data[31]); end
        for (int i = 16; i < 32; i++) begin
            checks++;
            if (rec_len[i] !== 1'b0 || rec_proto[i] !== 1'b0) begin
                errors++;
                $display("FAIL lane2_no_err cyc=%0d len=%0b proto=%0b exp 0", i, rec_len[i], rec_proto[i]);
            end
        end
    endtask

    task automatic test_len_err;
        reset_dut(0);
        expected_width = 16'd8;
        send_idle(20);
        send(W_SYNC0, 4'b0001);
        send(W_SYNC1, 4'b0001);
        send(W_LSTART, 4'b0001);
        send(32'hA0A0A0A0, 4'b0000);
        send(32'hB0B0B0B0, 4'b0000);
        send(32'hC0C0C0C0, 4'b0000);
        send(W_LEND, 4'b0001);
        send_idle(4);
        checks++; if (rec_len[27] !== 1'b0) begin errors++; $display("FAIL len_pre got=%0b exp=0", rec_len[27]); end
        checks++; if (rec_len[28] !== 1'b1) begin errors++; $display("FAIL len_pulse got=%0b exp=1", rec_len[28]); end
        checks++; if (rec_len[29] !== 1'b0) begin errors++; $display("FAIL len_post got=%0b exp=0", rec_len[29]); end
        checks++; if (rec_proto[28] !== 1'b0) begin errors++; $display("FAIL len_no_proto got=%0b exp=0", rec_proto[28]); end
        checks++; if (rec_lc[28] !== 16'd1) begin errors++; $display("FAIL len_line_cnt got=%0d exp=1", rec_lc[28]); end
    endtask

    task automatic test_odd_width;
        reset_dut(0);
        expected_width = 16'd9;
        send_idle(20);
        send(W_SYNC0, 4'b0001);
        send(W_SYNC1, 4'b0001);
        send(W_LSTART, 4'b0001);
        for (int i = 0; i < 4; i++) send(32'h01020304 + i, 4'b0000);
        send(W_LEND, 4'b0001);
        send_idle(4);
        checks++; if (rec_len[29] !== 1'b0) begin errors++; $display("FAIL odd_len got=%0b exp=0", rec_len[29]); end
        checks++; if (rec_lc[29] !== 16'd1) begin errors++; $display("FAIL odd_line_cnt got=%0d exp=1", rec_lc[29]); end
        checks++; if (rec_data[28] !== 32'h01020307) begin errors++; $display("FAIL odd_last_data got=%h exp=01020307", rec_data[28]); end
    endtask

    task automatic test_idle_data;
        reset_dut(0);
        expected_width = 16'd8;
        send_idle(20);
        send(32'hDEADBEEF, 4'b0000);
        send_idle(4);
        checks++; if (rec_proto[21] !== 1'b0) begin errors++; $display("FAIL idata_pre got=%0b exp=0", rec_proto[21]); end
        checks++; if (rec_proto[22] !== 1'b1) begin errors++; $display("FAIL idata_proto got=%0b exp=1", rec_proto[22]); end
        checks++; if (rec_de[22] !== 1'b0) begin errors++; $display("FAIL idata_de got=%0b exp=0", rec_de[22]); end
        checks++; if (rec_proto[23] !== 1'b0) begin errors++; $display("FAIL idata_post got=%0b exp=0", rec_proto[23]); end
        checks++; if (rec_locked[22] !== 1'b1) begin errors++; $display("FAIL idata_locked got=%0b exp=1", rec_locked[22]); end
    endtask

    task automatic test_unlock;
        reset_dut(0);
        expected_width = 16'd8;
        send_idle(20);
        send(W_SYNC0, 4'b0001);
        send(W_SYNC1, 4'b0001);
        send(W_LSTART, 4'b0001);
        send(32'h5A5A0001, 4'b0000);
        send(32'h5A5A0002, 4'b0000);
        for (int i = 0; i < 4; i++) send(32'h1234BCBC, 4'b0011);
        send_idle(22);
        checks++; if (rec_de[26] !== 1'b1) begin errors++; $display("FAIL unlk_de_before got=%0b exp=1", rec_de[26]); end
        checks++; if (rec_proto[27] !== 1'b1) begin errors++; $display("FAIL unlk_proto got=%0b exp=1", rec_proto[27]); end
        checks++; if (rec_de[27] !== 1'b0) begin errors++; $display("FAIL unlk_de_drop got=%0b exp=0", rec_de[27]); end
        checks++; if (rec_locked[29] !== 1'b1) begin errors++; $display("FAIL unlk_locked_3 got=%0b exp=1", rec_locked[29]); end
        checks++; if (rec_locked[30] !== 1'b0) begin errors++; $display("FAIL unlk_locked_4 got=%0b exp=0", rec_locked[30]); end
        checks++; if (rec_locked[45] !== 1'b0) begin errors++; $display("FAIL relock_early got=%0b exp=0", rec_locked[45]); end
        checks++; if (rec_locked[46] !== 1'b1) begin errors++; $display("FAIL relock_at16 got=%0b exp=1", rec_locked[46]); end
        for (int i = 31; i < 46; i++) begin
            checks++;
            if (rec_proto[i] !== 1'b0 || rec_de[i] !== 1'b0) begin
                errors++;
                $display("FAIL unlk_quiet cyc=%0d proto=%0b de=%0b exp 0", i, rec_proto[i], rec_de[i]);
            end
        end
    endtask

    task automatic test_reset_midline;
        reset_dut(1);
        expected_width = 16'd8;
        send_idle(20);
        send(W_SYNC0, 4'b0001);
        send(W_SYNC1, 4'b0001);
        send(W_LSTART, 4'b0001);
        send(32'h0BADF00D, 4'b0000);
        send(32'h0BADF00E, 4'b0000);
        send(32'h0BADF00F, 4'b0000);
        checks++; if (rec_de[25] !== 1'b1 || rec_data[25] !== 32'h0BADF00D) begin errors++; $display("FAIL mid_de de=%0b data=%h exp de=1 data=0badf00d", rec_de[25], rec_data[25]); end
        checks++; if (rec_lane[25] !== 2'd1) begin errors++; $display("FAIL mid_lane got=%0d exp=1", rec_lane[25]); end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (vout_de !== 1'b0 || vout_vs !== 1'b0 || vout_data !== 32'h0 || line_cnt !== 16'h0 || locked !== 1'b0 || lane !== 2'd0 || len_err !== 1'b0 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL async_rst de=%0b vs=%0b data=%h lc=%0d locked=%0b lane=%0d len=%0b proto=%0b exp all 0", vout_de, vout_vs, vout_data, line_cnt, locked, lane, len_err, proto_err);
        end
        reset_dut(1);
        send_idle(20);
        checks++; if (rec_locked[14] !== 1'b0) begin errors++; $display("FAIL mid_relock_early got=%0b exp=0", rec_locked[14]); end
        checks++; if (rec_locked[15] !== 1'b1) begin errors++; $display("FAIL mid_relock got=%0b exp=1", rec_locked[15]); end
        checks++; if (rec_lane[15] !== 2'd1) begin errors++; $display("FAIL mid_relock_lane got=%0d exp=1", rec_lane[15]); end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        cyc            = 0;
        tb_lane        = 0;
        idle_sel       = 1'b0;
        prev_w         = '0;
        prev_c         = '0;
        rst            = 1'b1;
        gt_rx_data     = '0;
        gt_rx_ctrl     = '0;
        expected_width = 16'd8;
        #1;
        test_reset;
        test_lock_lane0;
        test_line_lane2;
        test_len_err;
        test_odd_width;
        test_idle_data;
        test_unlock;
        test_reset_midline;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdmi_rx_unpack.md
Name: hdmi_rx_unpack

Overview:
- Receive-side counterpart of the GT video packer. Consumes the 32-bit GT RX word stream plus per-byte K flags.
- Recovers word alignment from the K28.5 (0xBC) comma, decodes the framing control words, and regenerates a frame-sync pulse and a line-gated 32-bit data stream (two 16-bit pixels per word).
- Sits between the GT RX user interface and the video write-back FIFO.
- Reports lock status, line count and framing errors.

Parameters:
- LOCK_CNT, 16, consecutive same-lane commas needed to declare lock.
- UNLOCK_CNT, 4, consecutive bad control words that drop lock.
- K_CHAR, 8'hBC, comma byte value.

Ports:
- rst  in  1  asynchronous, active-high reset
- tx_clk  in  1  clock; GT user clock, all logic in this domain
- gt_rx_data  in  32  raw GT RX word, byte 0 = bits[7:0]
- gt_rx_ctrl  in  4  per-byte K flag, bit i ↔ byte i
- expected_width  in  16  pixels per line (16-bit pixels); quasi-static
- vout_vs  out  1  one-cycle frame-start pulse
- vout_de  out  1  vout_data valid
- vout_data  out  32  aligned line payload word
- line_cnt  out  16  lines completed since last vout_vs
- locked  out  1  alignment locked
- lane  out  2  latched comma byte lane
- len_err  out  1  one-cycle pulse, line length mismatch
- proto_err  out  1  one-cycle pulse, framing violation

Behaviour:
- Reset (rst=1, async): all outputs 0; lock FSM UNLOCKED; parser IDLE; counters 0; pipeline regs 0.
- Pipeline
  - rx_d1 <= input, rx_d2 <= rx_d1, for both data and ctrl.
  - Aligned word = {rx_d1, rx_d2}[8*lane+31 : 8*lane]; aligned ctrl = {ctrl_d1, ctrl_d2}[lane+3 : lane].
  - Parser decodes the aligned word combinationally; all outputs are registered.
  - Latency: a word whose first byte is on the GT port in cycle n produces output in cycle n+3, for every lane.
- Lock FSM
  - Comma candidate (raw input word): exactly one ctrl bit set, and that byte == K_CHAR.
  - UNLOCKED:
    - Candidate in the same lane as the previous candidate: cnt+1.
    - Candidate in a different lane: cnt=1, new lane.
    - Ctrl with >1 bit set, or a K byte != K_CHAR: cnt=0.
    - ctrl==0000: cnt unchanged.
    - cnt reaching LOCK_CNT → LOCKED; lane latched; locked=1 from the next cycle.
  - LOCKED, evaluated on the aligned word:
    - Bad word = aligned ctrl not 0000/0001, or ctrl 0001 with byte0 != K_CHAR, or an unknown control code.
    - Bad-word counter clears on any good control word.
    - Reaching UNLOCK_CNT → UNLOCKED, cnt=0, locked=0.
  - While UNLOCKED: vout_de=0, vout_vs=0, no error pulses, parser forced IDLE.
- Control codes (aligned, ctrl=0001)
  - FF0000BC = SYNC0
  - FF0001BC = SYNC1
  - FF0002BC = LINE_START
  - FF0003BC = LINE_END
  - FF5555BC / FFAAAABC = IDLE
  - Any other ctrl=0001 word is unknown (bad word).
- Parser states: IDLE, SYNC_SEEN, LINE.
  - IDLE
    - SYNC0 → SYNC_SEEN.
    - LINE_START → LINE, word_cnt=0.
    - Data word (ctrl 0000) → proto_err, word dropped.
    - SYNC1 → proto_err.
    - IDLE code → stay.
  - SYNC_SEEN
    - SYNC1 → vout_vs=1, line_cnt=0, → IDLE.
    - Any other word → proto_err, → IDLE; that word is then also processed as in IDLE.
  - LINE
    - Data word: vout_de=1, vout_data=word, word_cnt+1, saturating at FFFF.
    - LINE_END → IDLE, line_cnt+1 (wraps).
      - Required word count = {1'b0, expected_width[15:1]}.
      - word_cnt != required count → len_err.
    - SYNC0 → proto_err, line aborted, → SYNC_SEEN.
    - Any other control word → proto_err, line aborted, → IDLE, line_cnt unchanged.
- Loss of lock in LINE: line aborted, proto_err pulse, → IDLE.
- Simultaneous len_err and proto_err cannot occur from one word.
- Odd expected_width: the last pixel is ignored (floor division).
- vout_data holds its last value when vout_de=0.

Test Plan:
- Idle stream FF5555BC/FFAAAABC, ctrl 0001, lane 0, after reset → locked=1 at the cycle after the 16th comma; lane=0; no outputs.
- Same stream rotated by 2 bytes (ctrl 0100) → lane=2; then SYNC0,SYNC1,LINE_START, 4 data words 0x11111111..0x44444444, LINE_END with expected_width=8 → vout_vs pulse; 4 de cycles with correct unrotated data, 3 cycles after each word's first byte; line_cnt=1; no errors.
- expected_width=8, line carrying 3 data words → len_err pulse on LINE_END; line_cnt=1.
- Locked, data word 0xDEADBEEF received in IDLE → proto_err pulse, vout_de stays 0.
- Mid-line, inject 4 words with ctrl 0011 → proto_err, vout_de drops, locked=0 after the 4th; relock after 16 commas.
- rst asserted mid-line → all outputs 0 immediately (async); after release, locked=0 until LOCK_CNT commas.
